// File: rtl/pcie_fifo_pkg.sv
// Shared helpers for the PCIe EP response FIFO: depth/last-bit computation
// and the sticky error flag record.
package pcie_fifo_pkg;

   typedef struct packed {
      logic ovf;
      logic udf;
   } err_flags_t;

   function automatic int fifo_depth(input int abits);
      return 32'sd1 << abits;
   endfunction

   function automatic int last_bit(input int dbits);
      return dbits - 32'sd1;
   endfunction

endpackage

// File: rtl/pcie_sfifo_mem.sv
// Storage array for the response FIFO: one synchronous write port and one
// combinational read port, no reset on the contents.
module pcie_sfifo_mem #(
   parameter int abits = 3,
   parameter int dbits = 73
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [abits-1:0] i_waddr,
   input  logic [dbits-1:0] i_wdata,
   input  logic [abits-1:0] i_raddr,
   output logic [dbits-1:0] o_rdata
);

   logic [dbits-1:0] r_mem [0:(1<<abits)-1];

   // write port
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pcie_resp_sfifo.sv
// Single-clock FWFT response FIFO between the DMA response generator and the
// EP TX arbiter, with occupancy, almost-full, optional packet gating and
// sticky overflow/underflow flags.
module pcie_resp_sfifo
   import pcie_fifo_pkg::*;
#(
   parameter int abits        = 3,
   parameter int dbits        = 73,
   parameter int afull_margin = 1,
   parameter int pkt_mode     = 0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_wr,
   input  logic [dbits-1:0] i_wdata,
   output logic             o_wfull,
   output logic             o_almost_full,
   input  logic             i_rd,
   output logic [dbits-1:0] o_rdata,
   output logic             o_rempty,
   output logic             o_pkt_valid,
   output logic [abits:0]   o_count,
   input  logic             i_err_clr,
   output logic             o_err_ovf,
   output logic             o_err_udf
);

   localparam int            DEPTH    = fifo_depth(abits);
   localparam int            LAST     = last_bit(dbits);
   localparam logic [31:0]   AFULL_TH = 32'(DEPTH - afull_margin);
   localparam logic [abits:0] ONE     = {{abits{1'b0}}, 1'b1};
   localparam logic [abits:0] ZERO    = {(abits+1){1'b0}};

   logic [abits:0]   r_wptr;
   logic [abits:0]   r_rptr;
   logic [abits:0]   r_count;
   logic [abits:0]   r_pkt_cnt;
   err_flags_t       r_err;

   logic             w_full;
   logic             w_empty;
   logic             w_wr_ok;
   logic             w_rd_ok;
   logic             w_wlast;
   logic             w_rlast;
   logic [abits:0]   w_count_nxt;
   logic [abits:0]   w_pkt_nxt;
   err_flags_t       w_err_nxt;
   logic [dbits-1:0] w_rdata;

   // Pointer MSB is the wrap bit: same address with differing wrap means full.
   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[abits-1:0] == r_rptr[abits-1:0]) &&
                    (r_wptr[abits] != r_rptr[abits]);

   assign w_wr_ok = i_wr & ~w_full;
   assign w_rd_ok = i_rd & ~w_empty;
   assign w_wlast = i_wdata[LAST];
   assign w_rlast = w_rdata[LAST];

   pcie_sfifo_mem #(
      .abits (abits),
      .dbits (dbits)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (w_wr_ok),
      .i_waddr (r_wptr[abits-1:0]),
      .i_wdata (i_wdata),
      .i_raddr (r_rptr[abits-1:0]),
      .o_rdata (w_rdata)
   );

   // next occupancy
   always_comb begin
      w_count_nxt = r_count;
      case ({w_wr_ok, w_rd_ok})
         2'b10:   w_count_nxt = r_count + ONE;
         2'b01:   w_count_nxt = r_count - ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // next count of fully buffered packets (one last beat per packet)
   always_comb begin
      w_pkt_nxt = r_pkt_cnt;
      case ({w_wr_ok & w_wlast, w_rd_ok & w_rlast})
         2'b10:   w_pkt_nxt = r_pkt_cnt + ONE;
         2'b01:   w_pkt_nxt = r_pkt_cnt - ONE;
         default: w_pkt_nxt = r_pkt_cnt;
      endcase
   end

   // sticky errors: a new error in the clear cycle wins over the clear
   always_comb begin
      w_err_nxt = r_err;
      if (i_wr && w_full) begin
         w_err_nxt.ovf = 1'b1;
      end else if (i_err_clr) begin
         w_err_nxt.ovf = 1'b0;
      end else begin
         w_err_nxt.ovf = r_err.ovf;
      end
      if (i_rd && w_empty) begin
         w_err_nxt.udf = 1'b1;
      end else if (i_err_clr) begin
         w_err_nxt.udf = 1'b0;
      end else begin
         w_err_nxt.udf = r_err.udf;
      end
   end

   // state registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr    <= ZERO;
         r_rptr    <= ZERO;
         r_count   <= ZERO;
         r_pkt_cnt <= ZERO;
         r_err     <= '{ovf: 1'b0, udf: 1'b0};
      end else begin
         r_wptr    <= r_wptr + (w_wr_ok ? ONE : ZERO);
         r_rptr    <= r_rptr + (w_rd_ok ? ONE : ZERO);
         r_count   <= w_count_nxt;
         r_pkt_cnt <= w_pkt_nxt;
         r_err     <= w_err_nxt;
      end
   end

   assign o_wfull       = w_full;
   assign o_rempty      = w_empty;
   assign o_rdata       = w_rdata;
   assign o_count       = r_count;
   assign o_almost_full = ({{(31-abits){1'b0}}, r_count} >= AFULL_TH);
   assign o_pkt_valid   = (pkt_mode != 32'sd0) ? (r_pkt_cnt != ZERO) : ~w_empty;
   assign o_err_ovf     = r_err.ovf;
   assign o_err_udf     = r_err.udf;

endmodule
